// File: rtl/tsc_pkg.sv
// Shared definitions for the time stamp counter sync controller and the TSC.
package tsc_pkg;

  // clk cycles in one nominal second (100 MHz system clock)
  localparam int unsigned CLKS_PER_SEC = 100000000;

  // Sequencer state codes as seen on sync_state
  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_WAIT_FIX = 3'd1,
    ST_QUALIFY  = 3'd2,
    ST_ARM      = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_TRACK    = 3'd5,
    ST_HOLDOVER = 3'd6
  } sync_state_t;

endpackage

// File: rtl/pps_watchdog.sv
// GPS PPS watchdog: counts clk cycles since the last PPS and flags the
// single cycle on which the count reaches the timeout.
module pps_watchdog #(
  parameter int unsigned TIMEOUT = 150000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pps,
  input  logic active,
  output logic expired
);

  localparam logic [27:0] LIMIT   = 28'(TIMEOUT);
  localparam logic [27:0] CNT_MAX = '1;

  logic [27:0] cnt;

  // Cycles since the last PPS; restarts on every PPS and parks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (pps) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 28'd1;
    end
  end

  assign expired = active && (cnt == LIMIT);

endmodule

// File: rtl/tsc_sync_ctl.sv
// Sequencing controller for the TSC and its phase/frequency detector:
// qualifies the GPS fix, arms TSC realignment, resyncs the PFD, judges
// lock from phase-difference samples and falls back to holdover.
module tsc_sync_ctl #(
  parameter int unsigned CLKS_PER_SEC  = tsc_pkg::CLKS_PER_SEC,
  parameter int unsigned PPS_TIMEOUT   = CLKS_PER_SEC + CLKS_PER_SEC / 2,
  parameter int unsigned FIX_QUAL_SEC  = 10,
  parameter int unsigned SETTLE_TRIG   = 4,
  parameter int unsigned LOCK_THRESH   = 100,
  parameter int unsigned LOCK_CNT      = 8,
  parameter int unsigned UNLOCK_THRESH = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sw_enable,
  input  logic        sw_resync,
  input  logic        gps_3dfix_d,
  input  logic        gps_1pps_d,
  input  logic        pll_trig,
  input  logic        pfd_status,
  input  logic [31:0] pdiff_1pps,
  output logic        tsc_sync,
  output logic        pfd_resync,
  output logic        locked,
  output logic        holdover,
  output logic [2:0]  sync_state,
  output logic [15:0] resync_cnt
);

  import tsc_pkg::*;

  localparam logic [15:0] QUAL_TGT   = 16'(FIX_QUAL_SEC);
  localparam logic [15:0] SETTLE_TGT = 16'(SETTLE_TRIG);
  localparam logic [15:0] LOCK_TGT   = 16'(LOCK_CNT);
  localparam logic [31:0] LOCK_LIM   = 32'(LOCK_THRESH);
  localparam logic [31:0] UNLOCK_LIM = 32'(UNLOCK_THRESH);
  localparam logic [15:0] RESYNC_MAX = 16'hFFFF;

  // Magnitude of a two's complement phase error; the most negative value
  // has no positive twin, so it is clamped to the largest positive one.
  function automatic logic [31:0] mag_sat(input logic [31:0] v);
    logic [31:0] m;
    if (v == 32'h8000_0000) begin
      m = 32'h7FFF_FFFF;
    end else if (v[31]) begin
      m = ~v + 32'd1;
    end else begin
      m = v;
    end
    return m;
  endfunction

  sync_state_t state, state_nxt;
  logic [15:0] qual_cnt, qual_nxt, qual_inc;
  logic [15:0] settle_cnt, settle_nxt, settle_inc;
  logic [15:0] good_cnt, good_nxt;
  logic        from_ho, from_ho_nxt;
  logic        settle_entry;
  logic        resync_entry;
  logic        gps_lost;
  logic        wd_active;
  logic        wd_expired;
  logic [31:0] pdiff_mag;

  assign wd_active = (state == ST_QUALIFY) || (state == ST_SETTLE) ||
                     (state == ST_TRACK);

  pps_watchdog #(
    .TIMEOUT (PPS_TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .pps     (gps_1pps_d),
    .active  (wd_active),
    .expired (wd_expired)
  );

  assign pdiff_mag  = mag_sat(pdiff_1pps);
  assign gps_lost   = !gps_3dfix_d || wd_expired;
  assign qual_inc   = qual_cnt + {15'd0, gps_1pps_d};
  assign settle_inc = settle_cnt + {15'd0, pll_trig};
  assign sync_state = state;

  // Next-state and counter update decisions, global overrides first
  always_comb begin
    state_nxt    = state;
    qual_nxt     = qual_cnt;
    from_ho_nxt  = from_ho;
    settle_nxt   = settle_cnt;
    good_nxt     = good_cnt;
    settle_entry = 1'b0;
    resync_entry = 1'b0;

    if (!sw_enable) begin
      state_nxt = ST_DISABLED;
    end else if (sw_resync && ((state == ST_SETTLE) || (state == ST_TRACK) ||
                               (state == ST_HOLDOVER))) begin
      state_nxt = ST_ARM;
    end else begin
      case (state)
        ST_DISABLED: state_nxt = ST_WAIT_FIX;
        ST_WAIT_FIX: begin
          if (gps_3dfix_d) begin
            state_nxt   = ST_QUALIFY;
            qual_nxt    = '0;
            from_ho_nxt = 1'b0;
          end
        end
        ST_QUALIFY: begin
          qual_nxt = qual_inc;
          if (gps_lost) begin
            state_nxt = ST_WAIT_FIX;
          end else if (qual_inc >= QUAL_TGT) begin
            // Coming back from holdover keeps the free-running TSC phase
            state_nxt = from_ho ? ST_SETTLE : ST_ARM;
          end
        end
        ST_ARM: begin
          if (!gps_3dfix_d) begin
            state_nxt = ST_WAIT_FIX;
          end else if (gps_1pps_d) begin
            state_nxt = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          settle_nxt = settle_inc;
          if (gps_lost) begin
            state_nxt = ST_HOLDOVER;
          end else if (settle_inc >= SETTLE_TGT) begin
            state_nxt = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (gps_lost) begin
            state_nxt = ST_HOLDOVER;
          end else if (pll_trig && locked && (pdiff_mag > UNLOCK_LIM)) begin
            state_nxt = ST_ARM;
          end else if (pfd_status) begin
            good_nxt = '0;
          end else if (pll_trig) begin
            if (pdiff_mag <= LOCK_LIM) begin
              good_nxt = (good_cnt >= LOCK_TGT) ? LOCK_TGT : good_cnt + 16'd1;
            end else begin
              good_nxt = '0;
            end
          end
        end
        ST_HOLDOVER: begin
          if (gps_3dfix_d && gps_1pps_d) begin
            state_nxt   = ST_QUALIFY;
            qual_nxt    = 16'd1;
            from_ho_nxt = 1'b1;
          end
        end
        default: state_nxt = ST_DISABLED;
      endcase
    end

    if ((state_nxt == ST_SETTLE) && (state != ST_SETTLE)) begin
      settle_entry = 1'b1;
      settle_nxt   = '0;
      good_nxt     = '0;
    end

    if ((state_nxt == ST_ARM) && ((state == ST_SETTLE) || (state == ST_TRACK) ||
                                  (state == ST_HOLDOVER))) begin
      resync_entry = 1'b1;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_DISABLED;
      qual_cnt   <= '0;
      settle_cnt <= '0;
      good_cnt   <= '0;
      from_ho    <= 1'b0;
      tsc_sync   <= 1'b0;
      pfd_resync <= 1'b0;
      locked     <= 1'b0;
      holdover   <= 1'b0;
      resync_cnt <= '0;
    end else begin
      state      <= state_nxt;
      qual_cnt   <= qual_nxt;
      settle_cnt <= settle_nxt;
      good_cnt   <= good_nxt;
      from_ho    <= from_ho_nxt;
      tsc_sync   <= (state_nxt == ST_ARM);
      pfd_resync <= settle_entry;
      locked     <= (state_nxt == ST_TRACK) && (good_nxt == LOCK_TGT);
      holdover   <= (state_nxt == ST_HOLDOVER);
      if (resync_entry && (resync_cnt != RESYNC_MAX)) begin
        resync_cnt <= resync_cnt + 16'd1;
      end
    end
  end

endmodule
